// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A INTA-cycle sequencer.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAS_HS,
        ACK1,
        ACK2_WAIT,
        VEC
    } pic_state_e;

    localparam logic       MODE_MASTER    = 1'b1;
    localparam logic       MODE_SLAVE     = 1'b0;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

endpackage

// File: rtl/pic_sync_edge.sv
// N-stage synchronizer for an asynchronous level, with one-clock rise/fall pulses.
module pic_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8086-mode INTA sequencer: raises INT, runs the cascade handshake, drives the
// vector on the second INTA and issues ISR-set / auto-EOI strobes.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inta_n,
    input  logic       int_req,
    input  logic [2:0] int_level,
    input  logic       sp,
    input  logic [4:0] icw2_base,
    input  logic [7:0] icw3,
    input  logic       aeoi,
    input  logic       cas_flag,
    input  logic       cas_ack,
    output logic       int_out,
    output logic       cas_strobe,
    output logic [2:0] desired_slave,
    output logic       isr_set,
    output logic [2:0] isr_level,
    output logic       eoi_pulse,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       cas_err
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic inta_lvl, inta_rise, inta_fall;
    logic ack_sync, ack_rise, ack_fall;
    logic unused_sync;

    pic_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_inta_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (inta_n),
        .q_o    (inta_lvl),
        .rise_o (inta_rise),
        .fall_o (inta_fall)
    );

    pic_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ack_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (cas_ack),
        .q_o    (ack_sync),
        .rise_o (ack_rise),
        .fall_o (ack_fall)
    );

    assign unused_sync = inta_lvl ^ ack_rise ^ ack_fall;

    pic_state_e       state_q, state_d;
    logic [2:0]       lvl_q, lvl_d, lvl_next;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_ref_q, ack_ref_d;
    logic             rise_pend_q, rise_pend_d;
    logic             fall_pend_q, fall_pend_d;
    logic [2:0]       dslave_q, dslave_d;
    logic             cas_err_q, cas_err_d;
    logic [7:0]       dout_q, dout_d;
    logic             doe_q, doe_d;
    logic             isr_set_q, isr_set_d;
    logic             eoi_q, eoi_d;
    logic             owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lvl_q       <= '0;
            sel_q       <= 1'b0;
            cnt_q       <= '0;
            ack_ref_q   <= 1'b0;
            rise_pend_q <= 1'b0;
            fall_pend_q <= 1'b0;
            dslave_q    <= '0;
            cas_err_q   <= 1'b0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            isr_set_q   <= 1'b0;
            eoi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            ack_ref_q   <= ack_ref_d;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            dslave_q    <= dslave_d;
            cas_err_q   <= cas_err_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            isr_set_q   <= isr_set_d;
            eoi_q       <= eoi_d;
        end
    end

    assign owner = ((sp == MODE_MASTER) && !icw3[lvl_q]) || ((sp == MODE_SLAVE) && sel_q);

    always_comb begin
        state_d     = state_q;
        lvl_d       = lvl_q;
        lvl_next    = lvl_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        rise_pend_d = rise_pend_q;
        fall_pend_d = fall_pend_q;
        dslave_d    = dslave_q;
        cas_err_d   = cas_err_q;
        dout_d      = dout_q;
        doe_d       = doe_q;
        isr_set_d   = 1'b0;
        eoi_d       = 1'b0;
        // Outside the handshake the reference tracks the pin, so only a toggle
        // made while the strobe is up counts as an acknowledge.
        ack_ref_d   = (state_q == CAS_HS) ? ack_ref_q : ack_sync;

        case (state_q)
            IDLE: begin
                rise_pend_d = 1'b0;
                fall_pend_d = 1'b0;
                if (int_req) state_d = REQ;
            end
            REQ: begin
                if (inta_fall) begin
                    if (int_req) begin
                        lvl_next  = int_level;
                        isr_set_d = 1'b1;
                    end else begin
                        lvl_next  = SPURIOUS_LEVEL;
                    end
                    lvl_d = lvl_next;
                    sel_d = 1'b0;
                    cnt_d = '0;
                    if ((sp == MODE_MASTER) && icw3[lvl_next]) begin
                        dslave_d = lvl_next;
                        state_d  = CAS_HS;
                    end else if (sp == MODE_SLAVE) begin
                        state_d  = CAS_HS;
                    end else begin
                        state_d  = ACK1;
                    end
                end
            end
            CAS_HS: begin
                if (inta_rise) rise_pend_d = 1'b1;
                if (inta_fall) fall_pend_d = 1'b1;
                if (ack_sync != ack_ref_q) begin
                    ack_ref_d = ack_sync;
                    if (sp == MODE_SLAVE) sel_d = cas_flag;
                    state_d = ACK1;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    cas_err_d = 1'b1;
                    sel_d     = 1'b0;
                    state_d   = ACK1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK1: begin
                if (inta_fall) fall_pend_d = 1'b1;
                if (inta_rise || rise_pend_q) begin
                    rise_pend_d = 1'b0;
                    state_d     = ACK2_WAIT;
                end
            end
            ACK2_WAIT: begin
                if (inta_fall || fall_pend_q) begin
                    fall_pend_d = 1'b0;
                    if (owner) begin
                        doe_d  = 1'b1;
                        dout_d = {icw2_base, lvl_q};
                    end
                    state_d = VEC;
                end
            end
            VEC: begin
                if (inta_rise) begin
                    doe_d  = 1'b0;
                    dout_d = '0;
                    eoi_d  = aeoi;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int_out    = 1'b0;
        cas_strobe = 1'b0;
        if (state_q != IDLE)   int_out    = 1'b1;
        if (state_q == CAS_HS) cas_strobe = 1'b1;
    end

    assign desired_slave = dslave_q;
    assign isr_set       = isr_set_q;
    assign isr_level     = lvl_q;
    assign eoi_pulse     = eoi_q;
    assign data_out      = dout_q;
    assign data_oe       = doe_q;
    assign cas_err       = cas_err_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: master, cascade, slave, spurious,
// timeout and mid-cycle reset scenarios with hand-computed expectations.
module tb_pic_inta_sequencer;

    logic       clk;
    logic       rst_n;
    logic       inta_n;
    logic       int_req;
    logic [2:0] int_level;
    logic       sp;
    logic [4:0] icw2_base;
    logic [7:0] icw3;
    logic       aeoi;
    logic       cas_flag;
    logic       cas_ack;
    logic       int_out;
    logic       cas_strobe;
    logic [2:0] desired_slave;
    logic       isr_set;
    logic [2:0] isr_level;
    logic       eoi_pulse;
    logic [7:0] data_out;
    logic       data_oe;
    logic       cas_err;

    logic [19:0] outs;
    int errors = 0;
    int checks = 0;
    int isr_cnt = 0;
    int eoi_cnt = 0;
    int oe_cnt  = 0;

    pic_inta_sequencer #(.SYNC_STAGES(2), .ACK_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inta_n        (inta_n),
        .int_req       (int_req),
        .int_level     (int_level),
        .sp            (sp),
        .icw2_base     (icw2_base),
        .icw3          (icw3),
        .aeoi          (aeoi),
        .cas_flag      (cas_flag),
        .cas_ack       (cas_ack),
        .int_out       (int_out),
        .cas_strobe    (cas_strobe),
        .desired_slave (desired_slave),
        .isr_set       (isr_set),
        .isr_level     (isr_level),
        .eoi_pulse     (eoi_pulse),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .cas_err       (cas_err)
    );

    assign outs = {int_out, cas_strobe, desired_slave, isr_set, isr_level,
                   eoi_pulse, data_out, data_oe, cas_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (isr_set)   isr_cnt++;
        if (eoi_pulse) eoi_cnt++;
        if (data_oe)   oe_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; inta_n = 1'b1; int_req = 1'b0; int_level = 3'd0;
        sp = 1'b1; icw2_base = 5'd0; icw3 = 8'h00; aeoi = 1'b0;
        cas_flag = 1'b0; cas_ack = 1'b0;
        ticks(2);
        checks++;
        if (outs !== 20'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", outs, 20'h0);
        end
        rst_n = 1'b1;
        ticks(3);
        checks++;
        if (outs !== 20'h0) begin
            errors++; $display("FAIL idle_outputs: got %h expected %h", outs, 20'h0);
        end
    endtask

    task automatic test_nc_master;
        int eoi0;
        sp = 1'b1; icw3 = 8'h00; icw2_base = 5'b01000; int_level = 3'd3; aeoi = 1'b0;
        eoi0 = eoi_cnt;
        int_req = 1'b1;
        ticks(1);
        checks++;
        if (int_out !== 1'b1) begin
            errors++; $display("FAIL nc_int_out_high: got %b expected 1", int_out);
        end
        inta_n = 1'b0;
        ticks(3);
        checks++;
        if ({isr_set, isr_level} !== {1'b1, 3'd3}) begin
            errors++; $display("FAIL nc_isr_set: got %b/%0d expected 1/3", isr_set, isr_level);
        end
        int_req = 1'b0;
        ticks(1);
        checks++;
        if (isr_set !== 1'b0) begin
            errors++; $display("FAIL nc_isr_pulse_width: got %b expected 0", isr_set);
        end
        ticks(2);
        inta_n = 1'b1;
        ticks(6);
        inta_n = 1'b0;
        ticks(3);
        checks++;
        if ({data_oe, data_out} !== {1'b1, 8'h43}) begin
            errors++; $display("FAIL nc_vector: got oe=%b data=%h expected oe=1 data=43", data_oe, data_out);
        end
        ticks(3);
        inta_n = 1'b1;
        ticks(3);
        checks++;
        if ({int_out, data_oe, data_out} !== 10'h0) begin
            errors++; $display("FAIL nc_end: got int=%b oe=%b data=%h expected 0/0/00", int_out, data_oe, data_out);
        end
        checks++;
        if (eoi_cnt !== eoi0) begin
            errors++; $display("FAIL nc_no_eoi: got %0d eoi pulses expected 0", eoi_cnt - eoi0);
        end
        ticks(3);
    endtask

    task automatic test_cascade_master;
        int oe0;
        sp = 1'b1; icw3 = 8'h04; icw2_base = 5'b01000; int_level = 3'd2; aeoi = 1'b0;
        oe0 = oe_cnt;
        int_req = 1'b1;
        ticks(1);
        inta_n = 1'b0;
        ticks(3);
        checks++;
        if ({cas_strobe, desired_slave, isr_set} !== {1'b1, 3'd2, 1'b1}) begin
            errors++; $display("FAIL casm_strobe: got strobe=%b slave=%0d isr=%b expected 1/2/1",
                               cas_strobe, desired_slave, isr_set);
        end
        int_req = 1'b0;
        ticks(3);
        cas_ack = ~cas_ack;
        ticks(2);
        checks++;
        if (cas_strobe !== 1'b1) begin
            errors++; $display("FAIL casm_strobe_hold: got %b expected 1", cas_strobe);
        end
        ticks(1);
        checks++;
        if ({cas_strobe, cas_err} !== 2'b00) begin
            errors++; $display("FAIL casm_strobe_drop: got strobe=%b err=%b expected 0/0", cas_strobe, cas_err);
        end
        inta_n = 1'b1;
        ticks(6);
        inta_n = 1'b0;
        ticks(6);
        checks++;
        if ({int_out, data_oe} !== 2'b10 || oe_cnt !== oe0) begin
            errors++; $display("FAIL casm_no_drive: got int=%b oe=%b oe_cycles=%0d expected 1/0/0",
                               int_out, data_oe, oe_cnt - oe0);
        end
        inta_n = 1'b1;
        ticks(6);
        checks++;
        if ({int_out, desired_slave} !== {1'b0, 3'd2}) begin
            errors++; $display("FAIL casm_end: got int=%b slave=%0d expected 0/2", int_out, desired_slave);
        end
    endtask

    task automatic test_slave;
        logic flag;
        logic [7:0] exp_data;
        for (int k = 0; k < 2; k++) begin
            flag = (k == 0);
            exp_data = flag ? 8'h85 : 8'h00;
            sp = 1'b0; icw3 = 8'h00; icw2_base = 5'b10000; int_level = 3'd5; aeoi = 1'b0;
            cas_flag = flag;
            int_req = 1'b1;
            ticks(1);
            inta_n = 1'b0;
            ticks(3);
            checks++;
            if ({cas_strobe, isr_set, isr_level} !== {1'b1, 1'b1, 3'd5}) begin
                errors++; $display("FAIL slave_strobe[%0d]: got strobe=%b isr=%b lvl=%0d expected 1/1/5",
                                   k, cas_strobe, isr_set, isr_level);
            end
            int_req = 1'b0;
            cas_ack = ~cas_ack;
            ticks(3);
            checks++;
            if (cas_strobe !== 1'b0) begin
                errors++; $display("FAIL slave_strobe_drop[%0d]: got %b expected 0", k, cas_strobe);
            end
            ticks(3);
            inta_n = 1'b1;
            ticks(6);
            inta_n = 1'b0;
            ticks(6);
            checks++;
            if ({data_oe, data_out} !== {flag, exp_data}) begin
                errors++; $display("FAIL slave_vector[%0d]: got oe=%b data=%h expected oe=%b data=%h",
                                   k, data_oe, data_out, flag, exp_data);
            end
            inta_n = 1'b1;
            ticks(6);
            checks++;
            if ({int_out, data_oe} !== 2'b00) begin
                errors++; $display("FAIL slave_end[%0d]: got int=%b oe=%b expected 0/0", k, int_out, data_oe);
            end
        end
        cas_flag = 1'b0;
    endtask

    task automatic test_spurious_aeoi;
        int isr0;
        sp = 1'b1; icw3 = 8'h00; icw2_base = 5'b01000; int_level = 3'd3; aeoi = 1'b1;
        isr0 = isr_cnt;
        int_req = 1'b1;
        ticks(1);
        int_req = 1'b0;
        ticks(2);
        checks++;
        if (int_out !== 1'b1) begin
            errors++; $display("FAIL spur_int_held: got %b expected 1", int_out);
        end
        inta_n = 1'b0;
        ticks(6);
        checks++;
        if (isr_cnt !== isr0) begin
            errors++; $display("FAIL spur_no_isr: got %0d isr pulses expected 0", isr_cnt - isr0);
        end
        inta_n = 1'b1;
        ticks(6);
        inta_n = 1'b0;
        ticks(6);
        checks++;
        if ({data_oe, data_out} !== {1'b1, 8'h47}) begin
            errors++; $display("FAIL spur_vector: got oe=%b data=%h expected oe=1 data=47", data_oe, data_out);
        end
        inta_n = 1'b1;
        ticks(3);
        checks++;
        if ({eoi_pulse, isr_level, int_out, data_oe} !== {1'b1, 3'd7, 1'b0, 1'b0}) begin
            errors++; $display("FAIL spur_eoi: got eoi=%b lvl=%0d int=%b oe=%b expected 1/7/0/0",
                               eoi_pulse, isr_level, int_out, data_oe);
        end
        ticks(1);
        checks++;
        if (eoi_pulse !== 1'b0) begin
            errors++; $display("FAIL spur_eoi_width: got %b expected 0", eoi_pulse);
        end
        aeoi = 1'b0;
        ticks(2);
    endtask

    task automatic test_timeout;
        sp = 1'b1; icw3 = 8'h04; icw2_base = 5'b01000; int_level = 3'd2; aeoi = 1'b0;
        int_req = 1'b1;
        ticks(1);
        inta_n = 1'b0;
        ticks(3);
        int_req = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            ticks(1);
            // Whole INTA edges land inside the handshake and must be held pending.
            if (i == 2) inta_n = 1'b1;
            if (i == 8) inta_n = 1'b0;
            if (i == 15) begin
                checks++;
                if ({cas_strobe, cas_err} !== 2'b10) begin
                    errors++; $display("FAIL tmo_before: got strobe=%b err=%b expected 1/0", cas_strobe, cas_err);
                end
            end
            if (i == 16) begin
                checks++;
                if ({cas_strobe, cas_err} !== 2'b01) begin
                    errors++; $display("FAIL tmo_expire: got strobe=%b err=%b expected 0/1", cas_strobe, cas_err);
                end
            end
        end
        ticks(4);
        checks++;
        if ({int_out, data_oe} !== 2'b10) begin
            errors++; $display("FAIL tmo_vec_wait: got int=%b oe=%b expected 1/0", int_out, data_oe);
        end
        inta_n = 1'b1;
        ticks(6);
        checks++;
        if ({int_out, cas_err} !== 2'b01) begin
            errors++; $display("FAIL tmo_end: got int=%b err=%b expected 0/1", int_out, cas_err);
        end
    endtask

    task automatic test_reset_midcycle;
        int isr0, eoi0;
        sp = 1'b1; icw3 = 8'h00; icw2_base = 5'b01000; int_level = 3'd3; aeoi = 1'b1;

        int_req = 1'b1;
        ticks(1);
        inta_n = 1'b0;
        ticks(3);
        int_req = 1'b0;
        ticks(3);
        inta_n = 1'b1;
        ticks(4);
        inta_n = 1'b0;
        ticks(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 20'h0) begin
            errors++; $display("FAIL rst_ack2: got %h expected %h", outs, 20'h0);
        end
        inta_n = 1'b1;
        isr0 = isr_cnt; eoi0 = eoi_cnt;
        ticks(2);
        rst_n = 1'b1;
        ticks(6);
        checks++;
        if (isr_cnt !== isr0 || eoi_cnt !== eoi0 || int_out !== 1'b0) begin
            errors++; $display("FAIL rst_ack2_quiet: got isr=%0d eoi=%0d int=%b expected 0/0/0",
                               isr_cnt - isr0, eoi_cnt - eoi0, int_out);
        end

        int_req = 1'b1;
        ticks(1);
        checks++;
        if (int_out !== 1'b1) begin
            errors++; $display("FAIL rst_restart: got %b expected 1", int_out);
        end
        inta_n = 1'b0;
        ticks(3);
        checks++;
        if ({isr_set, isr_level} !== {1'b1, 3'd3}) begin
            errors++; $display("FAIL rst_restart_isr: got %b/%0d expected 1/3", isr_set, isr_level);
        end
        int_req = 1'b0;
        ticks(3);
        inta_n = 1'b1;
        ticks(6);
        inta_n = 1'b0;
        ticks(4);
        checks++;
        if ({data_oe, data_out} !== {1'b1, 8'h43}) begin
            errors++; $display("FAIL rst_vec_pre: got oe=%b data=%h expected oe=1 data=43", data_oe, data_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 20'h0) begin
            errors++; $display("FAIL rst_vec: got %h expected %h", outs, 20'h0);
        end
        inta_n = 1'b1;
        isr0 = isr_cnt; eoi0 = eoi_cnt;
        ticks(2);
        rst_n = 1'b1;
        ticks(8);
        checks++;
        if (isr_cnt !== isr0 || eoi_cnt !== eoi0 || outs !== 20'h0) begin
            errors++; $display("FAIL rst_vec_quiet: got isr=%0d eoi=%0d outs=%h expected 0/0/0",
                               isr_cnt - isr0, eoi_cnt - eoi0, outs);
        end
        aeoi = 1'b0;
    endtask

    initial begin
        test_reset;
        test_nc_master;
        test_cascade_master;
        test_slave;
        test_spurious_aeoi;
        test_timeout;
        test_reset_midcycle;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
